// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Fetch stage of the 5-stage pipeline. Owns the program counter, issues word
// reads to instruction memory over a req/ack handshake, splits each 16-bit
// instruction into opcode/Rs/Rd/shmnt, fetches the trailing immediate word for
// immediate-class opcodes (opcode[4] == 1) and drives the fetch/decode pipeline
// register. Honours a stall from the hazard unit and PC redirects from later
// stages.
//
// Ports
//   clk, rst_n        clock (posedge) and asynchronous active-low reset
//   stall             hold delivery to decode and do not start new fetches
//   redirect_en/addr  load PC with redirect_addr and flush the current fetch
//   imem_req/addr     memory read request, held stable until imem_ack
//   imem_ack/rdata    memory read completion and data
//   Next_inst_addr    address following the delivered instruction
//   opcode/Rs/Rd/
//   shmnt/imm         decoded fields of the delivered instruction
//   fd_valid          one-cycle pulse per delivered instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int                 ADDR_W    = 32,
   parameter int                 INST_W    = 16,
   parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              redirect_en,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [31:0]       Next_inst_addr,
   output logic [4:0]        opcode,
   output logic [2:0]        Rs,
   output logic [2:0]        Rd,
   output logic [4:0]        shmnt,
   output logic [15:0]       imm,
   output logic              fd_valid
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_IMM,
      S_HOLD,
      S_DRAIN
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                req_q, req_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [INST_W-1:0]   buf_word_q, buf_word_d;
   logic [15:0]         buf_imm_q, buf_imm_d;
   logic [31:0]         nia_q, nia_d;
   logic [4:0]          opcode_q, opcode_d;
   logic [2:0]          rs_q, rs_d;
   logic [2:0]          rd_q, rd_d;
   logic [4:0]          shmnt_q, shmnt_d;
   logic [15:0]         imm_q, imm_d;
   logic                fd_valid_q, fd_valid_d;

   logic                done;
   logic [ADDR_W-1:0]   pc_p1;
   logic [ADDR_W-1:0]   pc_p2;
   logic                deliver;
   logic [INST_W-1:0]   dlv_word;
   logic [15:0]         dlv_imm;
   logic [ADDR_W-1:0]   dlv_nia;

   // An ack only counts while a request is outstanding.
   assign done  = req_q & imem_ack;
   assign pc_p1 = pc_q + ADDR_W'(1);
   assign pc_p2 = pc_q + ADDR_W'(2);

   // While in S_FETCH/S_IMM the PC points at the instruction word itself and
   // only advances when the whole instruction has been read; in S_HOLD it
   // already points past the buffered instruction.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_d      = req_q;
      addr_d     = addr_q;
      buf_word_d = buf_word_q;
      buf_imm_d  = buf_imm_q;
      nia_d      = nia_q;
      opcode_d   = opcode_q;
      rs_d       = rs_q;
      rd_d       = rd_q;
      shmnt_d    = shmnt_q;
      imm_d      = imm_q;
      fd_valid_d = 1'b0;
      deliver    = 1'b0;
      dlv_word   = '0;
      dlv_imm    = '0;
      dlv_nia    = '0;

      case (state_q)
         S_FETCH: begin
            if (done) begin
               if (!imem_rdata[15]) begin
                  pc_d = pc_p1;
                  if (!stall) begin
                     deliver  = 1'b1;
                     dlv_word = imem_rdata;
                     dlv_imm  = '0;
                     dlv_nia  = pc_p1;
                     req_d    = 1'b1;
                     addr_d   = pc_p1;
                  end else begin
                     buf_word_d = imem_rdata;
                     buf_imm_d  = '0;
                     req_d      = 1'b0;
                     state_d    = S_HOLD;
                  end
               end else begin
                  // The immediate word is fetched even under stall so the
                  // instruction is complete by the time decode can take it.
                  buf_word_d = imem_rdata;
                  req_d      = 1'b1;
                  addr_d     = pc_p1;
                  state_d    = S_IMM;
               end
            end else if (!req_q && !stall) begin
               req_d  = 1'b1;
               addr_d = pc_q;
            end
         end

         S_IMM: begin
            if (done) begin
               pc_d = pc_p2;
               if (!stall) begin
                  deliver  = 1'b1;
                  dlv_word = buf_word_q;
                  dlv_imm  = imem_rdata;
                  dlv_nia  = pc_p2;
                  req_d    = 1'b1;
                  addr_d   = pc_p2;
                  state_d  = S_FETCH;
               end else begin
                  buf_imm_d = imem_rdata;
                  req_d     = 1'b0;
                  state_d   = S_HOLD;
               end
            end
         end

         S_HOLD: begin
            if (!stall) begin
               deliver  = 1'b1;
               dlv_word = buf_word_q;
               dlv_imm  = buf_imm_q;
               dlv_nia  = pc_q;
               req_d    = 1'b1;
               addr_d   = pc_q;
               state_d  = S_FETCH;
            end
         end

         S_DRAIN: begin
            if (done) begin
               state_d = S_FETCH;
               req_d   = !stall;
               if (!stall) begin
                  addr_d = pc_q;
               end
            end
         end

         default: begin
            state_d = S_FETCH;
            req_d   = 1'b0;
         end
      endcase

      // A redirect overrides everything above. A request that is still
      // waiting for its ack cannot be withdrawn, so it is drained first with
      // its address held steady.
      if (redirect_en) begin
         deliver = 1'b0;
         pc_d    = redirect_addr;
         if (req_q && !imem_ack) begin
            state_d = S_DRAIN;
            req_d   = 1'b1;
            addr_d  = addr_q;
         end else begin
            state_d = S_FETCH;
            req_d   = !stall;
            if (!stall) begin
               addr_d = redirect_addr;
            end
         end
      end

      if (deliver) begin
         fd_valid_d = 1'b1;
         opcode_d   = dlv_word[15:11];
         rs_d       = dlv_word[10:8];
         rd_d       = dlv_word[7:5];
         shmnt_d    = dlv_word[4:0];
         imm_d      = dlv_imm;
         nia_d      = 32'(dlv_nia);
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_VEC;
         req_q      <= 1'b0;
         addr_q     <= '0;
         buf_word_q <= '0;
         buf_imm_q  <= '0;
         nia_q      <= '0;
         opcode_q   <= '0;
         rs_q       <= '0;
         rd_q       <= '0;
         shmnt_q    <= '0;
         imm_q      <= '0;
         fd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         buf_word_q <= buf_word_d;
         buf_imm_q  <= buf_imm_d;
         nia_q      <= nia_d;
         opcode_q   <= opcode_d;
         rs_q       <= rs_d;
         rd_q       <= rd_d;
         shmnt_q    <= shmnt_d;
         imm_q      <= imm_d;
         fd_valid_q <= fd_valid_d;
      end
   end

   assign imem_req       = req_q;
   assign imem_addr      = addr_q;
   assign Next_inst_addr = nia_q;
   assign opcode         = opcode_q;
   assign Rs             = rs_q;
   assign Rd             = rd_q;
   assign shmnt          = shmnt_q;
   assign imm            = imm_q;
   assign fd_valid       = fd_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. The bench plays instruction memory by hand,
// one clock at a time, and compares the DUT against hand-computed values.
// A second instance with RESET_VEC = 0xFFFFFFFF covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect_en;
   logic [31:0] redirect_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [31:0] nia;
   logic [4:0]  opcode;
   logic [2:0]  rs;
   logic [2:0]  rd;
   logic [4:0]  shmnt;
   logic [15:0] imm;
   logic        fd_valid;

   logic        rst2_n;
   logic        req2;
   logic [31:0] addr2;
   logic        ack2;
   logic [15:0] rdata2;
   logic [31:0] nia2;
   logic [4:0]  opcode2;
   logic [2:0]  rs2;
   logic [2:0]  rd2;
   logic [4:0]  shmnt2;
   logic [15:0] imm2;
   logic        fd_valid2;

   int total = 0;
   int bad   = 0;

   fetch_stage #(.ADDR_W(32), .INST_W(16), .RESET_VEC(32'h0000_0000)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect_en    (redirect_en),
      .redirect_addr  (redirect_addr),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .Next_inst_addr (nia),
      .opcode         (opcode),
      .Rs             (rs),
      .Rd             (rd),
      .shmnt          (shmnt),
      .imm            (imm),
      .fd_valid       (fd_valid)
   );

   fetch_stage #(.ADDR_W(32), .INST_W(16), .RESET_VEC(32'hFFFF_FFFF)) u_dut2 (
      .clk            (clk),
      .rst_n          (rst2_n),
      .stall          (1'b0),
      .redirect_en    (1'b0),
      .redirect_addr  (32'h0),
      .imem_req       (req2),
      .imem_addr      (addr2),
      .imem_ack       (ack2),
      .imem_rdata     (rdata2),
      .Next_inst_addr (nia2),
      .opcode         (opcode2),
      .Rs             (rs2),
      .Rd             (rd2),
      .shmnt          (shmnt2),
      .imm            (imm2),
      .fd_valid       (fd_valid2)
   );

   // Free-running clock, posedge at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Drive the main instance's inputs, then advance one clock and settle 1ns
   // past the edge so outputs are sampled away from it.
   task automatic applyStimulus(input logic ack, input logic [15:0] rdata,
                                input logic stl, input logic redir,
                                input logic [31:0] raddr);
      imem_ack      = ack;
      imem_rdata    = rdata;
      stall         = stl;
      redirect_en   = redir;
      redirect_addr = raddr;
      @(posedge clk);
      #1;
   endtask

   // Single comparison point.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Full decode-register check for the main instance.
   task automatic checkDecode(input string tag, input logic [4:0] op,
                              input logic [2:0] s, input logic [2:0] d,
                              input logic [4:0] sh, input logic [15:0] im,
                              input logic [31:0] na);
      checkOutput({tag, ".opcode"}, 32'(opcode), 32'(op));
      checkOutput({tag, ".Rs"},     32'(rs),     32'(s));
      checkOutput({tag, ".Rd"},     32'(rd),     32'(d));
      checkOutput({tag, ".shmnt"},  32'(shmnt),  32'(sh));
      checkOutput({tag, ".imm"},    32'(imm),    32'(im));
      checkOutput({tag, ".nia"},    nia,         na);
   endtask

   // Request-side check for the main instance.
   task automatic checkReq(input string tag, input logic fv, input logic rq,
                           input logic [31:0] ad);
      checkOutput({tag, ".fd_valid"}, 32'(fd_valid), 32'(fv));
      checkOutput({tag, ".req"},      32'(imem_req), 32'(rq));
      if (rq) begin
         checkOutput({tag, ".addr"}, imem_addr, ad);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      rst2_n        = 1'b0;
      stall         = 1'b0;
      redirect_en   = 1'b0;
      redirect_addr = '0;
      imem_ack      = 1'b0;
      imem_rdata    = '0;
      ack2          = 1'b0;
      rdata2        = '0;

      // Reset values.
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("rst.req",  32'(imem_req), 32'h0);
      checkOutput("rst.addr", imem_addr,     32'h0);
      checkOutput("rst.fdv",  32'(fd_valid), 32'h0);
      checkDecode("rst", 5'd0, 3'd0, 3'd0, 5'd0, 16'h0, 32'h0);

      // Sequential fetch of three words, one ack per request.
      rst_n = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      checkReq("seq.issue0", 1'b0, 1'b1, 32'd0);
      applyStimulus(1'b1, 16'h0A25, 1'b0, 1'b0, 32'h0);
      checkReq("seq.w0", 1'b1, 1'b1, 32'd1);
      checkDecode("seq.w0", 5'd1, 3'd2, 3'd1, 5'd5, 16'h0, 32'd1);
      applyStimulus(1'b1, 16'h1349, 1'b0, 1'b0, 32'h0);
      checkReq("seq.w1", 1'b1, 1'b1, 32'd2);
      checkDecode("seq.w1", 5'd2, 3'd3, 3'd2, 5'd9, 16'h0, 32'd2);
      applyStimulus(1'b1, 16'h2001, 1'b0, 1'b0, 32'h0);
      checkReq("seq.w2", 1'b1, 1'b1, 32'd3);
      checkDecode("seq.w2", 5'd4, 3'd0, 3'd0, 5'd1, 16'h0, 32'd3);
      applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 32'h0);
      checkReq("seq.w3", 1'b1, 1'b1, 32'd4);

      // Immediate-class instruction at 4 with its immediate at 5.
      applyStimulus(1'b1, 16'h8000, 1'b0, 1'b0, 32'h0);
      checkReq("imm.first", 1'b0, 1'b1, 32'd5);
      applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0, 32'h0);
      checkReq("imm.done", 1'b1, 1'b1, 32'd6);
      checkDecode("imm.done", 5'd16, 3'd0, 3'd0, 5'd0, 16'hBEEF, 32'd6);

      // Ack withheld for three cycles: request must sit still.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 16'hDEAD, 1'b0, 1'b0, 32'h0);
         checkReq($sformatf("wait.c%0d", i), 1'b0, 1'b1, 32'd6);
      end
      applyStimulus(1'b1, 16'h0863, 1'b0, 1'b0, 32'h0);
      checkReq("wait.ack", 1'b1, 1'b1, 32'd7);
      checkDecode("wait.ack", 5'd1, 3'd0, 3'd3, 5'd3, 16'h0, 32'd7);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      checkReq("wait.once", 1'b0, 1'b1, 32'd7);

      // Stall raised in the ack cycle and held four cycles.
      applyStimulus(1'b1, 16'h1125, 1'b1, 1'b0, 32'h0);
      checkReq("stall.ack", 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
         checkReq($sformatf("stall.h%0d", i), 1'b0, 1'b0, 32'd0);
      end
      checkOutput("stall.opcode_held", 32'(opcode), 32'd1);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      checkReq("stall.release", 1'b1, 1'b1, 32'd8);
      checkDecode("stall.release", 5'd2, 3'd1, 3'd1, 5'd5, 16'h0, 32'd8);

      // Redirect to 0x40 while the request at 8 is pending.
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 32'h40);
      checkReq("redir.cyc", 1'b0, 1'b1, 32'd8);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      checkReq("redir.drain", 1'b0, 1'b1, 32'd8);
      applyStimulus(1'b1, 16'h0A25, 1'b0, 1'b0, 32'h0);
      checkReq("redir.discard", 1'b0, 1'b1, 32'h40);
      checkOutput("redir.opcode_held", 32'(opcode), 32'd2);
      applyStimulus(1'b1, 16'h2001, 1'b0, 1'b0, 32'h0);
      checkReq("redir.target", 1'b1, 1'b1, 32'h41);
      checkDecode("redir.target", 5'd4, 3'd0, 3'd0, 5'd1, 16'h0, 32'h41);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);

      // PC wrap: non-imm word at 0xFFFFFFFF.
      rst2_n = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("wrap.req",  32'(req2), 32'h1);
      checkOutput("wrap.addr", addr2,     32'hFFFF_FFFF);
      ack2   = 1'b1;
      rdata2 = 16'h0A25;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("wrap.fdv",     32'(fd_valid2), 32'h1);
      checkOutput("wrap.nia",     nia2,           32'h0);
      checkOutput("wrap.nextreq", addr2,          32'h0);
      checkOutput("wrap.opcode",  32'(opcode2),   32'h1);

      // Reset asserted mid-request drops the request at once.
      ack2   = 1'b0;
      rst2_n = 1'b0;
      #1;
      checkOutput("wrap.rst_req", 32'(req2), 32'h0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      rst2_n = 1'b1;

      // PC wrap: imm-class word at 0xFFFFFFFF, immediate at 0.
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("wrapi.addr", addr2, 32'hFFFF_FFFF);
      ack2   = 1'b1;
      rdata2 = 16'h8000;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("wrapi.fdv0",  32'(fd_valid2), 32'h0);
      checkOutput("wrapi.immaddr", addr2,        32'h0);
      rdata2 = 16'h1234;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("wrapi.fdv1",   32'(fd_valid2), 32'h1);
      checkOutput("wrapi.opcode", 32'(opcode2),   32'd16);
      checkOutput("wrapi.imm",    32'(imm2),      32'h1234);
      checkOutput("wrapi.nia",    nia2,           32'h1);
      ack2 = 1'b0;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
